// File: rtl/push_pkg.sv
// Shared types and helpers for the push-button debouncer.
package push_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } push_state_e;

  localparam logic PUSH_IDLE = 1'b1;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/push_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, registered level and press pulse.
// Optional auto-repeat of the press pulse while held when PUSH_AUTOREPEAT_EN is defined.
//
// state      | meaning
// IDLE       | released, waiting for a low level
// PRESS_WAIT | low seen, counting stable low cycles
// HELD       | press accepted, output low
// REL_WAIT   | high seen, counting stable high cycles
module push_debounce_ch
  import push_pkg::*;
#(
  parameter int DEB_CYC    = 16,
  parameter int REPEAT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  output logic push_o,
  output logic pulse_o
);

  localparam int CW = cnt_width(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  if (DEB_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
    $error("push_debounce_ch: DEB_CYC and REPEAT_CYC must be >= 1");
  end

  logic [1:0]    sync_q, sync_d;
  push_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_o_q, push_o_d;
  logic          pulse_o_q, pulse_o_d;
  logic          s;
  logic          rep_fire;

  assign sync_d = {sync_q[0], push_i};
  assign s      = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{PUSH_IDLE}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      push_o_q  <= PUSH_IDLE;
      pulse_o_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      push_o_q  <= push_o_d;
      pulse_o_q <= pulse_o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s != PUSH_IDLE) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s == PUSH_IDLE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (s == PUSH_IDLE) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (s != PUSH_IDLE) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the accepting edge.
  always_comb begin
    push_o_d  = (state_d == HELD || state_d == REL_WAIT) ? ~PUSH_IDLE : PUSH_IDLE;
    pulse_o_d = (state_q == PRESS_WAIT && state_d == HELD) || rep_fire;
  end

`ifdef PUSH_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_q, rep_d;

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end

  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == HELD && state_d == HELD) begin
      if (rep_q == REP_LAST) rep_fire = 1'b1;
      else                   rep_d    = rep_q + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign push_o  = push_o_q;
  assign pulse_o = pulse_o_q;

endmodule

// File: rtl/push_debounce.sv
// N-channel push-button conditioner: independent debounce per channel.
// Auto-repeat pulses are enabled by defining PUSH_AUTOREPEAT_EN.
module push_debounce
  import push_pkg::*;
#(
  parameter int N          = 2,
  parameter int DEB_CYC    = 16,
  parameter int REPEAT_CYC = 64
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [N-1:0] Push_i,
  output logic [N-1:0] Push_o,
  output logic [N-1:0] Pulse_o
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    push_debounce_ch #(
      .DEB_CYC    (DEB_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_ch (
      .clk     (Clk),
      .rst     (Rst),
      .push_i  (Push_i[i]),
      .push_o  (Push_o[i]),
      .pulse_o (Pulse_o[i])
    );
  end

endmodule
